// File: rtl/dtw_trace_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dtw_trace_buffer_pkg
// Brief    : Path codes, FSM encodings and output-word packing for the DTW
//            trace buffer.
// Revision : 1.0 - initial release
// ============================================================================
package dtw_trace_buffer_pkg;

    typedef logic [1:0] path_t;

    localparam path_t PATH_NONE = 2'b00;
    localparam path_t PATH_LEFT = 2'b01;
    localparam path_t PATH_UP   = 2'b10;
    localparam path_t PATH_DIAG = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_EMIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Index header of an output word; D is appended by the caller.
    function automatic logic [15:0] pack_word(input logic [7:0] tidx, input logic [7:0] ridx);
        return {tidx, ridx};
    endfunction

endpackage
`default_nettype wire

// File: rtl/dtw_trace_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : dtw_trace_buffer_if
// Brief    : Write, control and output-stream signals of the DTW trace buffer.
// Revision : 1.0 - initial release
// ============================================================================
interface dtw_trace_buffer_if #(
    parameter int DATA_W = 16,
    parameter int TIDX_W = 5,
    parameter int RIDX_W = 5
);
    logic                     i_wr_valid;
    logic [TIDX_W-1:0]        i_wr_tidx;
    logic [RIDX_W-1:0]        i_wr_ridx;
    logic [DATA_W-1:0]        i_wr_d;
    logic [1:0]               i_wr_path;
    logic                     i_clear;
    logic                     i_start;
    logic [TIDX_W-1:0]        i_t_last;
    logic [RIDX_W-1:0]        i_r_last;
    logic                     o_valid;
    logic                     i_ready;
    logic [DATA_W+15:0]       o_data;
    logic                     o_busy;
    logic                     o_done;
    logic                     o_err;
    logic [TIDX_W+RIDX_W-1:0] o_steps;

    modport master (
        output i_wr_valid, i_wr_tidx, i_wr_ridx, i_wr_d, i_wr_path,
        output i_clear, i_start, i_t_last, i_r_last, i_ready,
        input  o_valid, o_data, o_busy, o_done, o_err, o_steps
    );

    modport slave (
        input  i_wr_valid, i_wr_tidx, i_wr_ridx, i_wr_d, i_wr_path,
        input  i_clear, i_start, i_t_last, i_r_last, i_ready,
        output o_valid, o_data, o_busy, o_done, o_err, o_steps
    );
endinterface
`default_nettype wire

// File: rtl/dtw_trace_buffer_path_store.sv
`default_nettype none
// ============================================================================
// Module   : dtw_trace_buffer_path_store
// Brief    : T_MAX x R_MAX store of {D,path}; one write port, one registered
//            read port. Path codes reset/clear to NONE, D is never reset.
// Revision : 1.0 - initial release
// ============================================================================
module dtw_trace_buffer_path_store
    import dtw_trace_buffer_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int TIDX_W = 5,
    parameter int RIDX_W = 5,
    parameter int T_MAX  = 16,
    parameter int R_MAX  = 16
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              clear,
    input  logic              wr_en,
    input  logic [TIDX_W-1:0] wr_t,
    input  logic [RIDX_W-1:0] wr_r,
    input  logic [DATA_W-1:0] wr_d,
    input  path_t             wr_path,
    input  logic              rd_en,
    input  logic [TIDX_W-1:0] rd_t,
    input  logic [RIDX_W-1:0] rd_r,
    output logic [DATA_W-1:0] rd_d,
    output path_t             rd_path
);
    localparam int TA_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;
    localparam int RA_W = (R_MAX > 1) ? $clog2(R_MAX) : 1;

    logic [DATA_W-1:0] r_d    [T_MAX][R_MAX];
    path_t             r_path [T_MAX][R_MAX];
    logic [DATA_W-1:0] r_rd_d;
    path_t             r_rd_path;

    // Callers guarantee in-range indices, so the truncation is lossless.
    logic [TA_W-1:0] w_wt, w_rt;
    logic [RA_W-1:0] w_wr, w_rr;
    assign w_wt = TA_W'(wr_t);
    assign w_wr = RA_W'(wr_r);
    assign w_rt = TA_W'(rd_t);
    assign w_rr = RA_W'(rd_r);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < T_MAX; i++)
                for (int j = 0; j < R_MAX; j++)
                    r_path[i][j] <= PATH_NONE;
        end else if (clear) begin
            for (int i = 0; i < T_MAX; i++)
                for (int j = 0; j < R_MAX; j++)
                    r_path[i][j] <= PATH_NONE;
        end else if (wr_en) begin
            r_path[w_wt][w_wr] <= wr_path;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_d[w_wt][w_wr] <= wr_d;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_rd_d    <= '0;
            r_rd_path <= PATH_NONE;
        end else if (rd_en) begin
            r_rd_d    <= r_d[w_rt][w_rr];
            r_rd_path <= r_path[w_rt][w_rr];
        end
    end

    assign rd_d    = r_rd_d;
    assign rd_path = r_rd_path;

endmodule
`default_nettype wire

// File: rtl/dtw_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module   : dtw_trace_buffer
// Brief    : DTW score/path store with traceback from (t_last,r_last) to the
//            origin, streaming one word per visited cell over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module dtw_trace_buffer
    import dtw_trace_buffer_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int TIDX_W = 5,
    parameter int RIDX_W = 5,
    parameter int T_MAX  = 16,
    parameter int R_MAX  = 16
) (
    input  logic               clk,
    input  logic               nrst,
    dtw_trace_buffer_if.slave  bus
);
    localparam int STEPS_W = TIDX_W + RIDX_W;

    logic [1:0]         r_state;
    logic [TIDX_W-1:0]  r_cur_t;
    logic [RIDX_W-1:0]  r_cur_r;
    logic [STEPS_W-1:0] r_steps;
    logic               r_valid;
    logic               r_busy;
    logic               r_done;
    logic               r_err;

    logic [DATA_W-1:0]  w_rd_d;
    path_t              w_rd_path;
    logic               w_idle;
    logic               w_wr_ok;
    logic               w_start_ok;
    logic               w_term;
    logic               w_illegal;

    assign w_idle     = (r_state == ST_IDLE);
    assign w_wr_ok    = w_idle && bus.i_wr_valid && !bus.i_clear
                        && (int'(bus.i_wr_tidx) < T_MAX) && (int'(bus.i_wr_ridx) < R_MAX);
    assign w_start_ok = (int'(bus.i_t_last) < T_MAX) && (int'(bus.i_r_last) < R_MAX);

    // A NONE code away from the origin is a legal early stop, not an error.
    assign w_term = ((r_cur_t == '0) && (r_cur_r == '0)) || (w_rd_path == PATH_NONE);

    always_comb begin
        w_illegal = 1'b0;
        case (w_rd_path)
            PATH_DIAG: w_illegal = (r_cur_t == '0) || (r_cur_r == '0);
            PATH_UP:   w_illegal = (r_cur_t == '0);
            PATH_LEFT: w_illegal = (r_cur_r == '0);
            default:   w_illegal = 1'b0;
        endcase
    end

    dtw_trace_buffer_path_store #(
        .DATA_W (DATA_W),
        .TIDX_W (TIDX_W),
        .RIDX_W (RIDX_W),
        .T_MAX  (T_MAX),
        .R_MAX  (R_MAX)
    ) u_store (
        .clk     (clk),
        .nrst    (nrst),
        .clear   (w_idle && bus.i_clear),
        .wr_en   (w_wr_ok),
        .wr_t    (bus.i_wr_tidx),
        .wr_r    (bus.i_wr_ridx),
        .wr_d    (bus.i_wr_d),
        .wr_path (bus.i_wr_path),
        .rd_en   (r_state == ST_FETCH),
        .rd_t    (r_cur_t),
        .rd_r    (r_cur_r),
        .rd_d    (w_rd_d),
        .rd_path (w_rd_path)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= ST_IDLE;
            r_cur_t <= '0;
            r_cur_r <= '0;
            r_steps <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.i_start) begin
                        if (w_start_ok) begin
                            r_cur_t <= bus.i_t_last;
                            r_cur_r <= bus.i_r_last;
                            r_steps <= '0;
                            r_err   <= 1'b0;
                            r_busy  <= 1'b1;
                            r_state <= ST_FETCH;
                        end else begin
                            r_err  <= 1'b1;
                            r_done <= 1'b1;
                        end
                    end
                end
                ST_FETCH: begin
                    r_valid <= 1'b1;
                    r_state <= ST_EMIT;
                end
                ST_EMIT: begin
                    if (bus.i_ready) begin
                        r_valid <= 1'b0;
                        if (r_steps != '1) begin
                            r_steps <= r_steps + STEPS_W'(1);
                        end
                        if (w_term) begin
                            r_state <= ST_DONE;
                        end else if (w_illegal) begin
                            r_err   <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            if (w_rd_path != PATH_LEFT) r_cur_t <= r_cur_t - TIDX_W'(1);
                            if (w_rd_path != PATH_UP)   r_cur_r <= r_cur_r - RIDX_W'(1);
                            r_state <= ST_FETCH;
                        end
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.o_valid = r_valid;
    assign bus.o_data  = {pack_word(8'(r_cur_t), 8'(r_cur_r)), w_rd_d};
    assign bus.o_busy  = r_busy;
    assign bus.o_done  = r_done;
    assign bus.o_err   = r_err;
    assign bus.o_steps = r_steps;

endmodule
`default_nettype wire

// File: tb/tb_dtw_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_dtw_trace_buffer
// Brief    : Directed self-checking bench for dtw_trace_buffer with a queue of
//            expected output words.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dtw_trace_buffer;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    dtw_trace_buffer_if #(.DATA_W(16), .TIDX_W(5), .RIDX_W(5)) bus ();

    dtw_trace_buffer #(
        .DATA_W (16),
        .TIDX_W (5),
        .RIDX_W (5),
        .T_MAX  (16),
        .R_MAX  (16)
    ) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    int n_pass = 0;
    int n_total = 0;
    int n_fail = 0;
    logic [31:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word(input int t, input int r, input int d);
        return {8'(t), 8'(r), 16'(d)};
    endfunction

    task automatic wr(input int t, input int r, input int d, input logic [1:0] p);
        bus.i_wr_valid = 1'b1;
        bus.i_wr_tidx  = 5'(t);
        bus.i_wr_ridx  = 5'(r);
        bus.i_wr_d     = 16'(d);
        bus.i_wr_path  = p;
        @(negedge clk);
        bus.i_wr_valid = 1'b0;
    endtask

    // Issues i_start and consumes words until o_done, comparing each accepted
    // word with the head of exp_q. Optionally stalls one word with i_ready low.
    task automatic trace(input string tag, input int t, input int r, input int n_exp,
                         input int steps_exp, input logic err_exp, input int stall_word,
                         input int stall_cyc, input bit chk_gap, input bit chk_lat);
        int cyc = 0;
        int words = 0;
        int last_hs = -1;
        int first_v = -1;
        int stalls = stall_cyc;
        bit done_seen = 1'b0;
        bus.i_t_last = 5'(t);
        bus.i_r_last = 5'(r);
        bus.i_start  = 1'b1;
        bus.i_ready  = 1'b1;
        @(negedge clk);
        bus.i_start    = 1'b0;
        bus.i_wr_valid = 1'b0;
        while (!done_seen && cyc < 200) begin
            cyc++;
            if (bus.o_done) done_seen = 1'b1;
            if (bus.o_valid) begin
                if (first_v < 0) first_v = cyc;
                if (words == stall_word && stalls > 0) begin
                    bus.i_ready = 1'b0;
                    stalls--;
                    if (exp_q.size() > 0) chk({tag, "_stall_hold"}, bus.o_data, exp_q[0]);
                end else begin
                    bus.i_ready = 1'b1;
                    if (exp_q.size() > 0) chk({tag, "_word"}, bus.o_data, exp_q.pop_front());
                    if (chk_gap && last_hs >= 0) chk({tag, "_gap"}, 32'(cyc - last_hs), 32'd2);
                    last_hs = cyc;
                    words++;
                end
            end
            if (!done_seen) @(negedge clk);
        end
        bus.i_ready = 1'b1;
        chk({tag, "_done_seen"}, 32'(done_seen), 32'd1);
        chk({tag, "_nwords"},    32'(words), 32'(n_exp));
        chk({tag, "_q_empty"},   32'(exp_q.size()), 32'd0);
        chk({tag, "_steps"},     32'(bus.o_steps), 32'(steps_exp));
        chk({tag, "_err"},       32'(bus.o_err), 32'(err_exp));
        chk({tag, "_busy"},      32'(bus.o_busy), 32'd0);
        if (chk_lat) chk({tag, "_latency"}, 32'(first_v), 32'd2);
        exp_q.delete();
    endtask

    initial begin
        bus.i_wr_valid = 1'b0;
        bus.i_wr_tidx  = '0;
        bus.i_wr_ridx  = '0;
        bus.i_wr_d     = '0;
        bus.i_wr_path  = '0;
        bus.i_clear    = 1'b0;
        bus.i_start    = 1'b0;
        bus.i_t_last   = '0;
        bus.i_r_last   = '0;
        bus.i_ready    = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(bus.o_valid), 32'd0);
        chk("rst_busy",  32'(bus.o_busy),  32'd0);
        chk("rst_done",  32'(bus.o_done),  32'd0);
        chk("rst_err",   32'(bus.o_err),   32'd0);
        chk("rst_steps", 32'(bus.o_steps), 32'd0);
        chk("rst_data",  bus.o_data,       32'd0);
        nrst = 1'b1;
        @(negedge clk);

        // Diagonal walk
        wr(0, 0, 0, 2'b00);
        for (int k = 1; k <= 3; k++) wr(k, k, k * 10, 2'b11);
        exp_q.push_back(word(3, 3, 30));
        exp_q.push_back(word(2, 2, 20));
        exp_q.push_back(word(1, 1, 10));
        exp_q.push_back(word(0, 0, 0));
        trace("diag", 3, 3, 4, 4, 1'b0, -1, 0, 1'b1, 1'b1);

        // Mixed up/left/diag walk
        wr(3, 2, 320, 2'b10);
        wr(2, 2, 220, 2'b01);
        wr(2, 1, 210, 2'b11);
        wr(1, 0, 100, 2'b10);
        exp_q.push_back(word(3, 2, 320));
        exp_q.push_back(word(2, 2, 220));
        exp_q.push_back(word(2, 1, 210));
        exp_q.push_back(word(1, 0, 100));
        exp_q.push_back(word(0, 0, 0));
        trace("mixed", 3, 2, 5, 5, 1'b0, -1, 0, 1'b1, 1'b0);

        // Backpressure on the second word
        exp_q.push_back(word(3, 2, 320));
        exp_q.push_back(word(2, 2, 220));
        exp_q.push_back(word(2, 1, 210));
        exp_q.push_back(word(1, 0, 100));
        exp_q.push_back(word(0, 0, 0));
        trace("stall", 3, 2, 5, 5, 1'b0, 1, 5, 1'b0, 1'b0);

        // Up step from t=0 is illegal after emitting the word
        wr(0, 2, 2, 2'b10);
        exp_q.push_back(word(0, 2, 2));
        trace("illegal", 0, 2, 1, 1, 1'b1, -1, 0, 1'b0, 1'b0);

        // Out-of-range start: error, no words, step count untouched
        trace("badstart", 20, 3, 0, 1, 1'b1, -1, 0, 1'b0, 1'b0);

        // Reset during EMIT
        bus.i_t_last = 5'd3;
        bus.i_r_last = 5'd3;
        bus.i_start  = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        for (int i = 0; i < 10 && !bus.o_valid; i++) @(negedge clk);
        chk("rst_mid_valid_before", 32'(bus.o_valid), 32'd1);
        #1 nrst = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(bus.o_valid), 32'd0);
        chk("rst_mid_busy",  32'(bus.o_busy),  32'd0);
        chk("rst_mid_err",   32'(bus.o_err),   32'd0);
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        exp_q.push_back(word(3, 3, 30));
        trace("post_rst", 3, 3, 1, 1, 1'b0, -1, 0, 1'b0, 1'b0);

        // Write and start in the same cycle
        bus.i_wr_valid = 1'b1;
        bus.i_wr_tidx  = 5'd4;
        bus.i_wr_ridx  = 5'd4;
        bus.i_wr_d     = 16'd77;
        bus.i_wr_path  = 2'b11;
        exp_q.push_back(word(4, 4, 77));
        exp_q.push_back(word(3, 3, 30));
        trace("wr_start", 4, 4, 2, 2, 1'b0, -1, 0, 1'b0, 1'b0);

        // Clear wins over a same-cycle write
        wr(3, 3, 33, 2'b11);
        bus.i_clear    = 1'b1;
        bus.i_wr_valid = 1'b1;
        bus.i_wr_tidx  = 5'd2;
        bus.i_wr_ridx  = 5'd2;
        bus.i_wr_d     = 16'd55;
        bus.i_wr_path  = 2'b11;
        @(negedge clk);
        bus.i_clear    = 1'b0;
        bus.i_wr_valid = 1'b0;
        exp_q.push_back(word(3, 3, 33));
        trace("clear", 3, 3, 1, 1, 1'b0, -1, 0, 1'b0, 1'b0);
        exp_q.push_back(word(2, 2, 220));
        trace("clear_wr", 2, 2, 1, 1, 1'b0, -1, 0, 1'b0, 1'b0);

        // Out-of-range write is dropped rather than aliased onto (0,0)
        wr(16, 0, 999, 2'b11);
        exp_q.push_back(word(0, 0, 0));
        trace("oor_wr", 0, 0, 1, 1, 1'b0, -1, 0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
